// File: rtl/ethernet_pkg.sv
// Shared Ethernet definitions for the clk156 datapath blocks.
//   arb_state_t : TX arbiter FSM states (ARB_GAP only reachable with ETH_TX_ARB_IFG_EN)
//   AXIS_DW     : AXI-Stream data width towards the 10G MAC
//   AXIS_KW     : AXI-Stream byte-enable width
package ethernet_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_XFER = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  localparam int AXIS_DW = 64;
  localparam int AXIS_KW = 8;

endpackage

// File: rtl/eth_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Searches req starting one position after `last`, wrapping modulo N, and
// returns the first requester found. `last` itself has the lowest priority.
//   req   in  N          request vector
//   last  in  $clog2(N)  previous winner
//   idx   out $clog2(N)  selected requester (0 when found=0)
//   found out 1          at least one request present
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IW = $clog2(N);

  // Walk from farthest to nearest so the nearest requester after `last` wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      int j;
      j = (int'(last) + k) % N;
      if (req[j]) begin
        idx   = IW'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: frame-granular round-robin arbiter sharing one 10G MAC TX
// AXI-Stream port among NPORT packet sources (clk156 domain).
// A granted source keeps the port until its tlast beat is accepted.
// Optional feature macro: ETH_TX_ARB_IFG_EN -- inserts IFG_CYC forced idle
// cycles (ARB_GAP) after each frame; without it the IFG_CYC parameter and
// the gap counter do not exist.
// Ports:
//   clk156, sys_rst_n           clock, synchronous active-low reset
//   port_en[NPORT]              per-source enable, looked at only when arbitrating
//   s_axis_*                    NPORT source streams (slice i = source i)
//   m_axis_tx_*                 stream to the MAC TX FIFO (tuser tied 0)
//   grant_idx                   current or last owner
//   busy                        high while a frame is being forwarded
module eth_tx_arb
  import ethernet_pkg::*;
#(
  parameter int NPORT = 4
`ifdef ETH_TX_ARB_IFG_EN
  ,
  parameter int IFG_CYC = 2
`endif
) (
  input  logic                       clk156,
  input  logic                       sys_rst_n,
  input  logic [NPORT-1:0]           port_en,
  input  logic [NPORT-1:0]           s_axis_tvalid,
  output logic [NPORT-1:0]           s_axis_tready,
  input  logic [NPORT*AXIS_DW-1:0]   s_axis_tdata,
  input  logic [NPORT*AXIS_KW-1:0]   s_axis_tkeep,
  input  logic [NPORT-1:0]           s_axis_tlast,
  output logic                       m_axis_tx_tvalid,
  input  logic                       m_axis_tx_tready,
  output logic [AXIS_DW-1:0]         m_axis_tx_tdata,
  output logic [AXIS_KW-1:0]         m_axis_tx_tkeep,
  output logic                       m_axis_tx_tlast,
  output logic                       m_axis_tx_tuser,
  output logic [$clog2(NPORT)-1:0]   grant_idx,
  output logic                       busy
);

  localparam int GW = $clog2(NPORT);

  arb_state_t      state, state_nxt;
  logic [GW-1:0]   grant_nxt;
  logic [NPORT-1:0] req;
  logic [GW-1:0]   pick_idx;
  logic            pick_found;
`ifdef ETH_TX_ARB_IFG_EN
  logic [15:0]     gap_cnt, gap_cnt_nxt;
`endif

  assign req             = s_axis_tvalid & port_en;
  assign busy            = (state == ARB_XFER);
  assign m_axis_tx_tuser = 1'b0;

  rr_pick #(
    .N (NPORT)
  ) u_pick (
    .req   (req),
    .last  (grant_idx),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State register
  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      state     <= ARB_IDLE;
      grant_idx <= GW'(NPORT - 1);
`ifdef ETH_TX_ARB_IFG_EN
      gap_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
`ifdef ETH_TX_ARB_IFG_EN
      gap_cnt   <= gap_cnt_nxt;
`endif
    end
  end

  // Next state and zero-latency datapath mux
  always_comb begin
    state_nxt        = state;
    grant_nxt        = grant_idx;
`ifdef ETH_TX_ARB_IFG_EN
    gap_cnt_nxt      = gap_cnt;
`endif
    s_axis_tready    = '0;
    m_axis_tx_tvalid = 1'b0;
    m_axis_tx_tdata  = '0;
    m_axis_tx_tkeep  = '0;
    m_axis_tx_tlast  = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          state_nxt = ARB_XFER;
        end
      end

      ARB_XFER: begin
        // port_en is deliberately not consulted here: an owner keeps the port
        // until its frame ends, even if disabled or stalled.
        m_axis_tx_tvalid         = s_axis_tvalid[grant_idx];
        m_axis_tx_tdata          = s_axis_tdata[int'(grant_idx)*AXIS_DW +: AXIS_DW];
        m_axis_tx_tkeep          = s_axis_tkeep[int'(grant_idx)*AXIS_KW +: AXIS_KW];
        m_axis_tx_tlast          = s_axis_tlast[grant_idx];
        s_axis_tready[grant_idx] = m_axis_tx_tready;
        if (m_axis_tx_tvalid && m_axis_tx_tready && m_axis_tx_tlast) begin
`ifdef ETH_TX_ARB_IFG_EN
          if (IFG_CYC == 0) begin
            state_nxt = ARB_IDLE;
          end else begin
            state_nxt   = ARB_GAP;
            gap_cnt_nxt = 16'(IFG_CYC);
          end
`else
          state_nxt = ARB_IDLE;
`endif
        end
      end

`ifdef ETH_TX_ARB_IFG_EN
      ARB_GAP: begin
        // Counter holds the number of gap cycles remaining including this one.
        if (gap_cnt <= 16'd1) begin
          state_nxt = ARB_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 16'd1;
        end
      end
`endif

      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
module tb_eth_tx_arb;

  localparam int NPORT = 4;
`ifdef ETH_TX_ARB_IFG_EN
  localparam int EXP_GAP = 5;  // tlast cycle -> 3 gap + 1 arbitration -> first beat
`else
  localparam int EXP_GAP = 2;  // tlast cycle -> 1 arbitration -> first beat
`endif

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic               clk156 = 1'b0;
  logic               sys_rst_n;
  logic [NPORT-1:0]   port_en;
  logic [NPORT-1:0]   s_tvalid;
  logic [NPORT-1:0]   s_tready;
  logic [NPORT*64-1:0] s_tdata;
  logic [NPORT*8-1:0] s_tkeep;
  logic [NPORT-1:0]   s_tlast;
  logic               m_tvalid;
  logic               m_tready;
  logic [63:0]        m_tdata;
  logic [7:0]         m_tkeep;
  logic               m_tlast;
  logic               m_tuser;
  logic [1:0]         grant_idx;
  logic               busy;

  eth_tx_arb #(
    .NPORT (NPORT)
`ifdef ETH_TX_ARB_IFG_EN
    , .IFG_CYC (3)
`endif
  ) dut (
    .clk156           (clk156),
    .sys_rst_n        (sys_rst_n),
    .port_en          (port_en),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .s_axis_tdata     (s_tdata),
    .s_axis_tkeep     (s_tkeep),
    .s_axis_tlast     (s_tlast),
    .m_axis_tx_tvalid (m_tvalid),
    .m_axis_tx_tready (m_tready),
    .m_axis_tx_tdata  (m_tdata),
    .m_axis_tx_tkeep  (m_tkeep),
    .m_axis_tx_tlast  (m_tlast),
    .m_axis_tx_tuser  (m_tuser),
    .grant_idx        (grant_idx),
    .busy             (busy)
  );

  always #5 clk156 = ~clk156;

  // Source drive queues and scoreboard queues
  beat_t src_q[NPORT][$];
  beat_t exp_q[NPORT][$];
  int    exp_order[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int seq = 0;
  logic [NPORT-1:0] acc;
  logic toggle_mode = 1'b0;
  bit   in_frame;
  bit   unexpected;
  int   cur_src;
  int   frame_start_cyc, last_cyc, last_gap, beats_in_frame, frames_done;
  int   tlast_cnt[NPORT];

  task automatic push_frame(input int src, input int nbeats);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.data = {8'(src), 8'(seq), 16'(k), 32'($urandom)};
      b.last = (k == nbeats - 1);
      b.keep = b.last ? 8'h0F : 8'hFF;
      src_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
    seq++;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      tlast_cnt[i] = 0;
    end
    exp_order.delete();
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
    port_en = '1; m_tready = 1'b1; toggle_mode = 1'b0;
    acc = '0; in_frame = 0; unexpected = 0; frames_done = 0;
    last_cyc = 0; last_gap = 0;
    repeat (2) @(negedge clk156);
    sys_rst_n = 1'b1;
  endtask

  // One clock: update sources for last cycle's handshakes, drive, then sample
  // the handshake that the coming posedge will perform.
  task automatic step();
    beat_t b;
    beat_t e;
    @(negedge clk156);
    for (int i = 0; i < NPORT; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    for (int i = 0; i < NPORT; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[64*i +: 64] = b.data;
        s_tkeep[8*i +: 8] = b.keep;
        s_tlast[i] = b.last;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[64*i +: 64] = '0;
        s_tkeep[8*i +: 8] = '0;
        s_tlast[i] = 1'b0;
      end
    end
    if (toggle_mode) m_tready = ~m_tready;
    #1;
    cyc++;
    acc = s_tvalid & s_tready;
    total_cnt++;
    if ($countones(s_tready) > 1) $display("FAIL tready_onehot: s_tready=%b required at most one bit", s_tready);
    else pass_cnt++;
    if (m_tvalid && m_tready) begin
      if (!in_frame) begin
        in_frame = 1;
        beats_in_frame = 0;
        last_gap = cyc - last_cyc;
        frame_start_cyc = cyc;
        total_cnt++;
        if (exp_order.size() == 0) begin
          unexpected = 1;
          $display("FAIL unexpected_frame: grant_idx=%0d required no frame", grant_idx);
        end else begin
          unexpected = 0;
          cur_src = exp_order.pop_front();
          if (grant_idx !== 2'(cur_src)) $display("FAIL grant_order: grant_idx=%0d required %0d", grant_idx, cur_src);
          else pass_cnt++;
        end
      end
      beats_in_frame++;
      if (!unexpected) begin
        total_cnt++;
        if (exp_q[cur_src].size() == 0) begin
          $display("FAIL extra_beat: src %0d data=%h required none", cur_src, m_tdata);
        end else begin
          e = exp_q[cur_src].pop_front();
          if ({m_tdata, m_tkeep, m_tlast} !== e)
            $display("FAIL beat_src%0d: got %h/%h/%b required %h/%h/%b",
                     cur_src, m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
          else pass_cnt++;
        end
      end
      if (m_tlast) begin
        in_frame = 0;
        last_cyc = cyc;
        frames_done++;
        if (!unexpected) tlast_cnt[cur_src]++;
      end
    end
  endtask

  task automatic run_until_idle(input string name, input int maxc);
    int n = 0;
    while ((exp_order.size() > 0 || in_frame) && n < maxc) begin
      step();
      n++;
    end
    total_cnt++;
    if (n >= maxc) $display("FAIL %s_timeout: frames left=%0d required 0", name, exp_order.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    port_en = '1; m_tready = 1'b1;
    s_tvalid = '1; s_tdata = {NPORT{64'hDEAD_BEEF_0123_4567}}; s_tkeep = '1; s_tlast = '0;
    repeat (5) @(negedge clk156);
    #1;
    total_cnt++; if (s_tready !== '0) $display("FAIL reset_s_tready: got %b required 0000", s_tready); else pass_cnt++;
    total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b required 0", m_tvalid); else pass_cnt++;
    total_cnt++; if (grant_idx !== 2'd3) $display("FAIL reset_grant_idx: got %0d required 3", grant_idx); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
    total_cnt++; if (m_tuser !== 1'b0) $display("FAIL tuser: got %b required 0", m_tuser); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_single_source();
    int req_cyc;
    push_frame(2, 6);
    exp_order.push_back(2);
    req_cyc = cyc + 1;
    run_until_idle("single", 50);
    total_cnt++;
    if (frame_start_cyc - req_cyc !== 1) $display("FAIL single_latency: got %0d required 1", frame_start_cyc - req_cyc);
    else pass_cnt++;
    total_cnt++;
    if (beats_in_frame !== 6) $display("FAIL single_beats: got %0d required 6", beats_in_frame); else pass_cnt++;
    total_cnt++;
    if (grant_idx !== 2'd2) $display("FAIL single_grant: got %0d required 2", grant_idx); else pass_cnt++;
  endtask

  task automatic test_all_sources();
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NPORT; i++) begin
        push_frame(i, 3);
        exp_order.push_back(i);
      end
    run_until_idle("all", 200);
    for (int i = 0; i < NPORT; i++) begin
      total_cnt++;
      if (tlast_cnt[i] !== 2) $display("FAIL all_tlast_cnt%0d: got %0d required 2", i, tlast_cnt[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    bit prev_stall = 0;
    logic [63:0] held;
    do_reset();
    m_tready = 1'b0;
    toggle_mode = 1'b1;
    push_frame(1, 5);
    exp_order.push_back(1);
    while ((exp_order.size() > 0 || in_frame) && n < 60) begin
      step();
      n++;
      if (busy) begin
        total_cnt++;
        if (s_tready !== (4'(m_tready) << 1)) $display("FAIL bp_tready: got %b required %b", s_tready, 4'(m_tready) << 1);
        else pass_cnt++;
        if (prev_stall) begin
          total_cnt++;
          if (m_tdata !== held) $display("FAIL bp_stable: got %h required %h", m_tdata, held);
          else pass_cnt++;
        end
        prev_stall = m_tvalid && !m_tready;
        held = m_tdata;
      end else begin
        prev_stall = 0;
      end
    end
    total_cnt++;
    if (n >= 60) $display("FAIL bp_timeout: frames left=%0d required 0", exp_order.size()); else pass_cnt++;
    toggle_mode = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic test_port_en();
    int n = 0;
    bit cleared = 0;
    do_reset();
    port_en = 4'b1101;
    push_frame(0, 3); push_frame(1, 3); push_frame(2, 3); push_frame(3, 3); push_frame(0, 4);
    exp_order.push_back(0); exp_order.push_back(2); exp_order.push_back(3); exp_order.push_back(0);
    while ((exp_order.size() > 0 || in_frame) && n < 200) begin
      step();
      n++;
      if (!cleared && in_frame && frames_done == 3) begin
        port_en[0] = 1'b0;
        cleared = 1;
      end
    end
    total_cnt++;
    if (n >= 200) $display("FAIL pe_timeout: frames left=%0d required 0", exp_order.size()); else pass_cnt++;
    repeat (6) step();
    total_cnt++;
    if (tlast_cnt[0] !== 2) $display("FAIL pe_src0_frames: got %0d required 2", tlast_cnt[0]); else pass_cnt++;
    total_cnt++;
    if (tlast_cnt[1] !== 0) $display("FAIL pe_src1_granted: got %0d frames required 0", tlast_cnt[1]); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_frame(3, 3); push_frame(3, 3);
    exp_order.push_back(3); exp_order.push_back(3);
    run_until_idle("b2b", 100);
    total_cnt++;
    if (last_gap !== EXP_GAP) $display("FAIL b2b_gap: got %0d cycles required %0d", last_gap, EXP_GAP);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_all_sources();
    test_backpressure();
    test_port_en();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
